// File: rtl/date_counter.sv
// Calendar stage: edge-detects day_enable to advance date/month/year/day-of-week, and accepts
// validated user date loads over a valid/ready handshake. Optional macro LEAP_YEAR_EN enables leap Februaries.
module date_counter #(
    parameter int unsigned YEAR_W    = 7,
    parameter int unsigned YEAR_MAX  = 99,
    parameter int unsigned RESET_DOW = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              day_enable,
    input  logic              set_valid,
    output logic              set_ready,
    input  logic [4:0]        set_date,
    input  logic [3:0]        set_month,
    input  logic [YEAR_W-1:0] set_year,
    input  logic [2:0]        set_dow,
    output logic [4:0]        date_out,
    output logic [3:0]        month_out,
    output logic [YEAR_W-1:0] year_out,
    output logic [2:0]        dow_out,
    output logic              year_wrap,
    output logic              set_error
);

    localparam logic [YEAR_W-1:0] YearMax  = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] YearOne  = YEAR_W'(1);
    localparam logic [2:0]        ResetDow = 3'(RESET_DOW);

    typedef enum logic {StIdle, StCheck} state_t;

    state_t            state_q;
    logic              day_en_q;
    logic [4:0]        sh_date_q;
    logic [3:0]        sh_month_q;
    logic [YEAR_W-1:0] sh_year_q;
    logic [2:0]        sh_dow_q;

    logic              adv;
    logic              cur_leap;
    logic              sh_leap;
    logic [4:0]        cur_len;
    logic [4:0]        sh_len;
    logic              load_ok;
    logic [4:0]        nxt_date;
    logic [3:0]        nxt_month;
    logic [YEAR_W-1:0] nxt_year;
    logic [2:0]        nxt_dow;
    logic              nxt_wrap;

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
            4'd2:                    month_len = leap ? 5'd29 : 5'd28;
            default:                 month_len = 5'd31;
        endcase
    endfunction

`ifdef LEAP_YEAR_EN
    // Every year divisible by 4 is leap inside 2000..2099.
    assign cur_leap = (year_out[1:0] == 2'b00);
    assign sh_leap  = (sh_year_q[1:0] == 2'b00);
`else
    assign cur_leap = 1'b0;
    assign sh_leap  = 1'b0;
`endif

    assign adv     = day_enable & ~day_en_q;
    assign cur_len = month_len(month_out, cur_leap);
    assign sh_len  = month_len(sh_month_q, sh_leap);
    assign load_ok = (sh_month_q >= 4'd1) && (sh_month_q <= 4'd12) &&
                     (sh_date_q != 5'd0) && (sh_date_q <= sh_len) &&
                     (sh_year_q <= YearMax) && (sh_dow_q <= 3'd6);

    always_comb begin
        nxt_date  = date_out;
        nxt_month = month_out;
        nxt_year  = year_out;
        nxt_wrap  = 1'b0;
        nxt_dow   = (dow_out == 3'd6) ? 3'd0 : dow_out + 3'd1;
        if (date_out < cur_len) begin
            nxt_date = date_out + 5'd1;
        end else begin
            nxt_date = 5'd1;
            if (month_out == 4'd12) begin
                nxt_month = 4'd1;
                if (year_out == YearMax) begin
                    nxt_year = '0;
                    nxt_wrap = 1'b1;
                end else begin
                    nxt_year = year_out + YearOne;
                end
            end else begin
                nxt_month = month_out + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            day_en_q   <= 1'b0;
            sh_date_q  <= 5'd1;
            sh_month_q <= 4'd1;
            sh_year_q  <= '0;
            sh_dow_q   <= 3'd0;
            set_ready  <= 1'b1;
            date_out   <= 5'd1;
            month_out  <= 4'd1;
            year_out   <= '0;
            dow_out    <= ResetDow;
            year_wrap  <= 1'b0;
            set_error  <= 1'b0;
        end else begin
            day_en_q  <= day_enable;
            year_wrap <= 1'b0;
            set_error <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A load accepted this cycle takes priority; a coincident advance is dropped.
                    if (set_valid) begin
                        sh_date_q  <= set_date;
                        sh_month_q <= set_month;
                        sh_year_q  <= set_year;
                        sh_dow_q   <= set_dow;
                        set_ready  <= 1'b0;
                        state_q    <= StCheck;
                    end else if (adv) begin
                        date_out  <= nxt_date;
                        month_out <= nxt_month;
                        year_out  <= nxt_year;
                        dow_out   <= nxt_dow;
                        year_wrap <= nxt_wrap;
                    end
                end
                StCheck: begin
                    if (load_ok) begin
                        date_out  <= sh_date_q;
                        month_out <= sh_month_q;
                        year_out  <= sh_year_q;
                        dow_out   <= sh_dow_q;
                    end else begin
                        set_error <= 1'b1;
                    end
                    set_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
